// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg : opcodes, sequencer state encoding and strobe bundle              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [2:0] OP_HLT  = 3'd0;
    localparam logic [2:0] OP_SKZ  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ANDD = 3'd3;
    localparam logic [2:0] OP_XORR = 3'd4;
    localparam logic [2:0] OP_LDA  = 3'd5;
    localparam logic [2:0] OP_STO  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_S0     = 4'd1,
        ST_S1     = 4'd2,
        ST_S2     = 4'd3,
        ST_S3     = 4'd4,
        ST_S4     = 4'd5,
        ST_S5     = 4'd6,
        ST_S6     = 4'd7,
        ST_S7     = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

    typedef struct packed {
        logic fetch;
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic alu_ena;
        logic datactl_ena;
        logic halt;
    } strobe_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_seq_ctrl_if : sequencer <-> datapath control bundle                    |
// | CPU_SEQ_STEP_EN adds the single-step input.                                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cpu_seq_ctrl_if #(
    parameter int OPC_W  = 3,
    parameter int ICNT_W = 16
);
    logic              ena;
    logic [OPC_W-1:0]  opcode;
    logic              zero;
`ifdef CPU_SEQ_STEP_EN
    logic              step;
`endif
    logic              fetch;
    logic              rd;
    logic              wr;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              load_acc;
    logic              alu_ena;
    logic              datactl_ena;
    logic              halt;
    logic [ICNT_W-1:0] icount;

    modport master (
`ifdef CPU_SEQ_STEP_EN
        input  step,
`endif
        input  ena, opcode, zero,
        output fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc,
        output alu_ena, datactl_ena, halt, icount
    );

    modport slave (
`ifdef CPU_SEQ_STEP_EN
        output step,
`endif
        output ena, opcode, zero,
        input  fetch, rd, wr, load_ir, inc_pc, load_pc, load_acc,
        input  alu_ena, datactl_ena, halt, icount
    );
endinterface : cpu_seq_ctrl_if
`default_nettype wire

// File: rtl/cpu_seq_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_seq_decode : combinational strobe table (next state, opcode, zero)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cpu_seq_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  state_t           state_nxt,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output strobe_t          strobes
);
    logic is_alu;
    logic is_skz;
    logic is_sto;
    logic is_jmp;
    logic is_legal;

    // Unknown opcode bits make every compare false, so X decodes as a no-op.
    always_comb begin
        is_skz   = (opcode == OPC_W'(OP_SKZ));
        is_sto   = (opcode == OPC_W'(OP_STO));
        is_jmp   = (opcode == OPC_W'(OP_JMP));
        is_alu   = (opcode == OPC_W'(OP_ADD))  || (opcode == OPC_W'(OP_ANDD)) ||
                   (opcode == OPC_W'(OP_XORR)) || (opcode == OPC_W'(OP_LDA));
        is_legal = is_alu || is_skz || is_sto || is_jmp || (opcode == OPC_W'(OP_HLT));
    end

    always_comb begin
        strobes = '0;
        case (state_nxt)
            ST_S0: begin
                strobes.fetch   = 1'b1;
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
            end
            ST_S1: begin
                strobes.fetch   = 1'b1;
                strobes.rd      = 1'b1;
                strobes.load_ir = 1'b1;
                strobes.inc_pc  = 1'b1;
            end
            ST_S2, ST_S3: strobes.fetch = 1'b1;
            ST_S4: begin
                if (is_alu) strobes.rd          = 1'b1;
                if (is_sto) strobes.datactl_ena = 1'b1;
                if (is_jmp) strobes.load_pc     = 1'b1;
            end
            ST_S5: begin
                if (is_legal) strobes.alu_ena = 1'b1;
                if (is_alu) begin
                    strobes.rd       = 1'b1;
                    strobes.load_acc = 1'b1;
                end
                if (is_sto) begin
                    strobes.wr          = 1'b1;
                    strobes.datactl_ena = 1'b1;
                end
                if (is_skz && zero) strobes.inc_pc = 1'b1;
            end
            ST_S6: begin
                if (is_alu) strobes.rd          = 1'b1;
                if (is_sto) strobes.datactl_ena = 1'b1;
            end
            ST_HALTED: strobes.halt = 1'b1;
            default: ;
        endcase
    end
endmodule : cpu_seq_decode
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_seq_ctrl : 8-cycle instruction sequencer with retired-instr counter    |
// | CPU_SEQ_STEP_EN enables single-stepping out of HALTED.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int OPC_W  = 3,
    parameter int ICNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    cpu_seq_ctrl_if.master bus
);
    state_t              state_q, state_d;
    strobe_t             strobe_q, strobe_d;
    logic [ICNT_W-1:0]   icount_q, icount_d;
`ifdef CPU_SEQ_STEP_EN
    logic                stepping_q, stepping_d;
`endif

    cpu_seq_decode #(.OPC_W(OPC_W)) u_decode (
        .state_nxt (state_d),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .strobes   (strobe_d)
    );

    always_comb begin
        state_d  = state_q;
        icount_d = icount_q;
`ifdef CPU_SEQ_STEP_EN
        stepping_d = stepping_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.ena) state_d = ST_S0;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = (bus.opcode == OPC_W'(OP_HLT)) ? ST_HALTED : ST_S4;
            ST_S4:   state_d = ST_S5;
            ST_S5:   state_d = ST_S6;
            ST_S6:   state_d = ST_S7;
            ST_S7: begin
                icount_d = (icount_q == '1) ? icount_q : icount_q + ICNT_W'(1);
                state_d  = bus.ena ? ST_S0 : ST_IDLE;
`ifdef CPU_SEQ_STEP_EN
                if (stepping_q) state_d = ST_HALTED;
`endif
            end
            ST_HALTED: begin
`ifdef CPU_SEQ_STEP_EN
                if (bus.step) begin
                    state_d    = ST_S0;
                    stepping_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef CPU_SEQ_STEP_EN
        // Any arrival in HALTED (step completion or an executed HLT) ends the step.
        if (state_d == ST_HALTED) stepping_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            strobe_q <= '0;
            icount_q <= '0;
`ifdef CPU_SEQ_STEP_EN
            stepping_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            icount_q <= icount_d;
`ifdef CPU_SEQ_STEP_EN
            stepping_q <= stepping_d;
`endif
        end
    end

    assign bus.fetch       = strobe_q.fetch;
    assign bus.rd          = strobe_q.rd;
    assign bus.wr          = strobe_q.wr;
    assign bus.load_ir     = strobe_q.load_ir;
    assign bus.inc_pc      = strobe_q.inc_pc;
    assign bus.load_pc     = strobe_q.load_pc;
    assign bus.load_acc    = strobe_q.load_acc;
    assign bus.alu_ena     = strobe_q.alu_ena;
    assign bus.datactl_ena = strobe_q.datactl_ena;
    assign bus.halt        = strobe_q.halt;
    assign bus.icount      = icount_q;
endmodule : cpu_seq_ctrl
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_seq_ctrl : directed self-checking bench for cpu_seq_ctrl            |
// | Step test compiled only with CPU_SEQ_STEP_EN.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cpu_seq_ctrl;
    // Strobe vector order: fetch rd wr load_ir inc_pc load_pc load_acc alu_ena datactl_ena halt
    localparam logic [9:0] V_S0   = 10'b1101000000;
    localparam logic [9:0] V_S1   = 10'b1101100000;
    localparam logic [9:0] V_F    = 10'b1000000000;
    localparam logic [9:0] V_Z    = 10'b0000000000;
    localparam logic [9:0] V_HALT = 10'b0000000001;

    localparam logic [79:0] E_ALU  = {V_S0, V_S1, V_F, V_F, 10'b0100000000,
                                      10'b0100001100, 10'b0100000000, V_Z};
    localparam logic [79:0] E_SKZ1 = {V_S0, V_S1, V_F, V_F, V_Z, 10'b0000100100, V_Z, V_Z};
    localparam logic [79:0] E_SKZ0 = {V_S0, V_S1, V_F, V_F, V_Z, 10'b0000000100, V_Z, V_Z};
    localparam logic [79:0] E_STO  = {V_S0, V_S1, V_F, V_F, 10'b0000000010,
                                      10'b0010000110, 10'b0000000010, V_Z};
    localparam logic [79:0] E_JMP  = {V_S0, V_S1, V_F, V_F, 10'b0000010000,
                                      10'b0000000100, V_Z, V_Z};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_icnt = 0;

    cpu_seq_ctrl_if #(.OPC_W(3), .ICNT_W(16)) bus ();

    cpu_seq_ctrl #(.OPC_W(3), .ICNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] strobes();
        return {bus.fetch, bus.rd, bus.wr, bus.load_ir, bus.inc_pc, bus.load_pc,
                bus.load_acc, bus.alu_ena, bus.datactl_ena, bus.halt};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [79:0] exp, input bit clr_after_s0);
        bus.opcode = op;
        bus.zero   = z;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("%s S%0d", tag, i), {22'd0, strobes()}, {22'd0, exp[79-10*i -: 10]});
            if (i == 0) begin
                check_eq($sformatf("%s icount", tag), {16'd0, bus.icount}, exp_icnt);
                if (clr_after_s0) begin
                    bus.ena = 1'b0;
`ifdef CPU_SEQ_STEP_EN
                    bus.step = 1'b0;
`endif
                end
            end
        end
        exp_icnt++;
    endtask

    task automatic run_hlt(input string tag);
        bus.opcode = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("%s S%0d", tag, i), {22'd0, strobes()},
                     {22'd0, (i == 0) ? V_S0 : (i == 1) ? V_S1 : V_F});
            if (i == 0) check_eq($sformatf("%s icount", tag), {16'd0, bus.icount}, exp_icnt);
        end
        tick();
        check_eq($sformatf("%s halted", tag), {22'd0, strobes()}, {22'd0, V_HALT});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        bus.ena    = 1'b1;
        bus.opcode = 3'd5;
        bus.zero   = 1'b0;
`ifdef CPU_SEQ_STEP_EN
        bus.step   = 1'b0;
`endif
        repeat (3) tick();
        check_eq("reset strobes", {22'd0, strobes()}, 32'd0);
        check_eq("reset icount", {16'd0, bus.icount}, 32'd0);

        rst = 1'b1;
        run_instr("lda",  3'd5, 1'b0, E_ALU,  1'b0);
        run_instr("skz1", 3'd1, 1'b1, E_SKZ1, 1'b0);
        run_instr("skz0", 3'd1, 1'b0, E_SKZ0, 1'b0);
        run_instr("sto",  3'd6, 1'b0, E_STO,  1'b0);
        run_instr("jmp",  3'd7, 1'b0, E_JMP,  1'b0);

        run_hlt("hlt");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("hlt hold", {22'd0, strobes()}, {22'd0, V_HALT});
            check_eq("hlt icount", {16'd0, bus.icount}, exp_icnt);
        end
        rst = 1'b0;
        tick();
        exp_icnt = 0;
        check_eq("hlt rst strobes", {22'd0, strobes()}, 32'd0);
        check_eq("hlt rst icount", {16'd0, bus.icount}, 32'd0);

        // Abort an ADD in S5 with reset.
        rst = 1'b1;
        bus.opcode = 3'd2;
        repeat (6) tick();
        check_eq("add S5", {22'd0, strobes()}, {22'd0, 10'b0100001100});
        rst = 1'b0;
        tick();
        check_eq("abort strobes", {22'd0, strobes()}, 32'd0);
        check_eq("abort icount", {16'd0, bus.icount}, 32'd0);
        rst = 1'b1;
        bus.ena = 1'b0;
        tick();
        check_eq("idle hold", {22'd0, strobes()}, 32'd0);

        bus.ena = 1'b1;
        run_instr("ena_drop", 3'd2, 1'b0, E_ALU, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post idle", {22'd0, strobes()}, 32'd0);
        end
        check_eq("post idle icount", {16'd0, bus.icount}, exp_icnt);

`ifdef CPU_SEQ_STEP_EN
        bus.ena = 1'b1;
        run_hlt("step_hlt");
        bus.ena  = 1'b0;
        bus.step = 1'b1;
        run_instr("step_add", 3'd2, 1'b0, E_ALU, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("step rehalt", {22'd0, strobes()}, {22'd0, V_HALT});
            check_eq("step icount", {16'd0, bus.icount}, exp_icnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_cpu_seq_ctrl
`default_nettype wire
